// File: rtl/pushdly_prm_if.sv
// pushdly_prm_if: delay-line bus; master drives din/delay/flush, slave returns dout/rdy
interface pushdly_prm_if #(
    parameter int WIDTH = 1,
    parameter int AW = 5
);
    logic [WIDTH-1:0] din;
    logic [AW-1:0] delay;
    logic flush;
    logic [WIDTH-1:0] dout;
    logic rdy;
    modport master (output din, delay, flush, input dout, rdy);
    modport slave (input din, delay, flush, output dout, rdy);
endinterface

// File: rtl/pushdly_prm.sv
// pushdly_prm: programmable D+3 cycle delay line; clk/rst plain ports, bus.slave carries din/delay/flush in and registered dout/rdy out
module pushdly_prm #(
    parameter int WIDTH = 1,
    parameter int AW = 5
) (
    input logic clk,
    input logic rst,
    pushdly_prm_if.slave bus
);
    typedef enum logic {FILL, RUN} state_t;
    localparam int FW = AW + 2;
    state_t state_q, state_d;
    logic [FW-1:0] fc_q, fc_d;
    logic [AW-1:0] wp_q, dr_q, raddr;
    logic [WIDTH-1:0] din_q, rd_q, dout_q;
    logic restart, fill_done;
    logic [WIDTH-1:0] mem [2**AW];
    assign raddr = wp_q - dr_q;
    assign bus.dout = dout_q;
    assign bus.rdy = state_q == RUN;
    always_comb begin
        restart = bus.flush || (bus.delay != dr_q);
        fill_done = fc_q == ({2'b00, dr_q} + FW'(2));
        state_d = restart ? FILL : ((state_q == RUN || fill_done) ? RUN : FILL);
        fc_d = (restart || state_q == RUN || fill_done) ? '0 : fc_q + FW'(1);
    end
    always_ff @(posedge clk) mem[wp_q] <= din_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fc_q <= '0;
            wp_q <= '0;
            dr_q <= bus.delay;
            din_q <= '0;
            rd_q <= '0;
            dout_q <= '0;
        end else begin
            state_q <= state_d;
            fc_q <= fc_d;
            wp_q <= wp_q + AW'(1);
            dr_q <= bus.delay;
            din_q <= bus.din;
            // zero delay reads the slot being written this cycle, so take the write data directly
            rd_q <= (dr_q == '0) ? din_q : mem[raddr];
            dout_q <= (state_d == RUN) ? rd_q : '0;
        end
    end
endmodule

// File: tb/tb_pushdly_prm.sv
// tb_pushdly_prm: randomized delay-line bench against a cycle-history reference model
module tb_pushdly_prm;
    localparam int WIDTH = 8;
    localparam int AW = 5;
    localparam int N = 8000;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pushdly_prm_if #(.WIDTH(WIDTH), .AW(AW)) bus ();
    pushdly_prm #(.WIDTH(WIDTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errors = 0;
    int t = 0;
    int s = 1;
    logic [WIDTH-1:0] din_h [N];
    int dly_h [N];
    logic exp_rdy;
    logic [WIDTH-1:0] exp_dout;

    task automatic cyc(input logic [WIDTH-1:0] d, input int dly, input logic fl, input logic r);
        int dd, idx;
        @(posedge clk);
        #1;
        t++;
        if (t >= N - 1) begin
            $display("FAIL cycle_budget t=%0d limit %0d", t, N);
            $fatal(1);
        end
        dd = dly_h[t-1];
        exp_rdy = t >= s + dd + 3;
        idx = exp_rdy ? t - dd - 3 : 0;
        exp_dout = exp_rdy ? din_h[idx] : '0;
        rst = r;
        bus.din = d;
        bus.delay = AW'(dly);
        bus.flush = fl;
        din_h[t] = d;
        dly_h[t] = dly;
        if (r || fl || dly != dly_h[t-1]) s = t + 1;
    endtask

    task automatic test_reset();
        int first = -1;
        int r;
        cyc('0, 5, 1'b0, 1'b1);
        checks++;
        if (bus.rdy !== 1'b0 || bus.dout !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%b dout=%h expected 0 00", bus.rdy, bus.dout);
        end
        r = t + 1;
        for (int i = 0; i < 14; i++) begin
            cyc(WIDTH'($urandom), 5, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL reset_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL reset_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1 && first < 0) first = t;
        end
        checks++;
        if (first != r + 8) begin errors++; $display("FAIL reset_rdy_rise got cycle %0d exp %0d", first, r + 8); end
    endtask

    task automatic test_pulse();
        int p = 0;
        int hits = 0;
        int hit_at = -1;
        for (int i = 0; i < 20; i++) cyc('0, 7, 1'b0, 1'b0);
        checks++;
        if (bus.rdy !== 1'b1) begin errors++; $display("FAIL pulse_ready got %b exp 1", bus.rdy); end
        cyc(8'h01, 7, 1'b0, 1'b0);
        p = t;
        for (int i = 0; i < 20; i++) begin
            cyc('0, 7, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL pulse_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL pulse_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.dout !== '0) begin hits++; hit_at = t; end
        end
        checks++;
        if (hits != 1 || hit_at != p + 10) begin errors++; $display("FAIL pulse_once hits=%0d at %0d exp 1 at %0d", hits, hit_at, p + 10); end
    endtask

    task automatic test_sweep();
        int p, lat;
        for (int d = 0; d < 32; d++) begin
            for (int i = 0; i < d + 5; i++) cyc('0, d, 1'b0, 1'b0);
            cyc(8'hA5, d, 1'b0, 1'b0);
            p = t;
            lat = -1;
            for (int i = 0; i < d + 6; i++) begin
                cyc('0, d, 1'b0, 1'b0);
                checks += 2;
                if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL sweep_rdy d=%0d t=%0d got %b exp %b", d, t, bus.rdy, exp_rdy); end
                if (bus.dout !== exp_dout) begin errors++; $display("FAIL sweep_dout d=%0d t=%0d got %h exp %h", d, t, bus.dout, exp_dout); end
                if (bus.dout === 8'hA5 && lat < 0) lat = t - p;
            end
            checks++;
            if (lat != d + 3) begin errors++; $display("FAIL sweep_latency d=%0d got %0d exp %0d", d, lat, d + 3); end
        end
    endtask

    task automatic test_delay_change();
        int lows = 0;
        for (int i = 0; i < 20; i++) cyc(WIDTH'($urandom), 10, 1'b0, 1'b0);
        cyc(WIDTH'($urandom), 3, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(WIDTH'($urandom), 3, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL change_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL change_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1) break;
            lows++;
        end
        checks++;
        if (lows != 6) begin errors++; $display("FAIL change_fill_len got %0d exp 6", lows); end
        for (int i = 0; i < 15; i++) begin
            cyc(WIDTH'($urandom), 3, 1'b0, 1'b0);
            checks++;
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL change_run_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
        end
    endtask

    task automatic test_flush_stale();
        int stale = 0;
        for (int i = 0; i < 40; i++) cyc(8'hFF, 5, 1'b0, 1'b0);
        cyc('0, 5, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc('0, 5, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL flush_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL flush_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1 && bus.dout === 8'hFF) stale++;
        end
        checks++;
        if (stale != 0) begin errors++; $display("FAIL flush_stale got %0d stale words exp 0", stale); end
    endtask

    task automatic test_flush_and_change();
        int lows;
        for (int i = 0; i < 15; i++) cyc(WIDTH'($urandom), 4, 1'b0, 1'b0);
        cyc(WIDTH'($urandom), 9, 1'b1, 1'b0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(WIDTH'($urandom), 9, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL fc_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL fc_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1) break;
            lows++;
        end
        checks++;
        if (lows != 12) begin errors++; $display("FAIL fc_fill_len got %0d exp 12", lows); end
        for (int i = 0; i < 5; i++) cyc(WIDTH'($urandom), 9, 1'b0, 1'b0);
        cyc(WIDTH'($urandom), 9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(WIDTH'($urandom), 9, 1'b0, 1'b0);
        cyc(WIDTH'($urandom), 2, 1'b0, 1'b0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(WIDTH'($urandom), 2, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL fc2_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL fc2_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1) break;
            lows++;
        end
        checks++;
        if (lows != 5) begin errors++; $display("FAIL fc_restart_len got %0d exp 5", lows); end
    endtask

    task automatic test_reset_mid_run();
        int lows = 0;
        for (int i = 0; i < 45; i++) cyc(WIDTH'(t + 1), 31, 1'b0, 1'b0);
        checks++;
        if (bus.rdy !== 1'b1) begin errors++; $display("FAIL rst_run_ready got %b exp 1", bus.rdy); end
        cyc(WIDTH'(t + 1), 31, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc(WIDTH'(t + 1), 31, 1'b0, 1'b0);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL rst_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL rst_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
            if (bus.rdy === 1'b1) break;
            lows++;
        end
        checks++;
        if (lows != 34) begin errors++; $display("FAIL rst_fill_len got %0d exp 34", lows); end
        for (int i = 0; i < 60; i++) begin
            cyc(WIDTH'(t + 1), 31, 1'b0, 1'b0);
            checks++;
            if (bus.dout !== WIDTH'(t - 34)) begin errors++; $display("FAIL rst_wrap_dout t=%0d got %h exp %h", t, bus.dout, WIDTH'(t - 34)); end
        end
    endtask

    task automatic test_random();
        int dly = 6;
        logic fl, r;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(29) == 0) dly = int'($urandom_range(31));
            fl = $urandom_range(24) == 0;
            r = $urandom_range(199) == 0;
            cyc(WIDTH'($urandom), dly, fl, r);
            checks += 2;
            if (bus.rdy !== exp_rdy) begin errors++; $display("FAIL rand_rdy t=%0d got %b exp %b", t, bus.rdy, exp_rdy); end
            if (bus.dout !== exp_dout) begin errors++; $display("FAIL rand_dout t=%0d got %h exp %h", t, bus.dout, exp_dout); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.din = '0;
        bus.delay = AW'(5);
        bus.flush = 1'b0;
        din_h[0] = '0;
        dly_h[0] = 5;
        test_reset();
        test_pulse();
        test_sweep();
        test_delay_change();
        test_flush_stale();
        test_flush_and_change();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
